// File: rtl/coprocessor_perf_count_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : coprocessor_perf_count_multi_if
// Description : Slave-transfer bus bundle for the multi-section perf counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface coprocessor_perf_count_multi_if #(
    parameter int AW = 3
);
    logic [AW-1:0] address;
    logic          begintransfer;
    logic          write;
    logic          read;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output address, begintransfer, write, read, writedata,
        input  readdata
    );

    modport slave (
        input  address, begintransfer, write, read, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/coprocessor_perf_count_multi.sv
`default_nettype none
// ============================================================================
// Module      : coprocessor_perf_count_multi
// Description : Multi-section time/event performance counters with snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module coprocessor_perf_count_multi #(
    parameter int NUM_SECTIONS = 2,
    parameter int TIME_WIDTH   = 64,
    parameter int EVENT_WIDTH  = 32,
    parameter int SATURATE     = 0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    coprocessor_perf_count_multi_if.slave bus
);
    localparam int AW     = ($clog2(4 * NUM_SECTIONS) > 2) ? $clog2(4 * NUM_SECTIONS) : 2;
    localparam int SNAP_W = TIME_WIDTH - 32;

    logic                          w_wr_strobe;
    logic                          w_rd_strobe;
    logic [31:0]                   w_addr_ext;
    logic [31:0]                   w_sec_idx;
    logic [1:0]                    w_off;
    logic [NUM_SECTIONS-1:0]       w_stop;
    logic [NUM_SECTIONS-1:0]       w_go;
    logic [NUM_SECTIONS-1:0]       w_run;
    logic [NUM_SECTIONS-1:0][31:0] w_sec_rd;
    logic                          w_global_clear;
    logic                          w_global_enable;
    logic [31:0]                   w_rd_mux;
    logic [31:0]                   r_readdata;
    logic                          w_unused;

    assign w_wr_strobe     = bus.write & bus.begintransfer;
    assign w_rd_strobe     = bus.read  & bus.begintransfer;
    assign w_addr_ext      = {{(32-AW){1'b0}}, bus.address};
    assign w_sec_idx       = w_addr_ext >> 2;
    assign w_off           = bus.address[1:0];
    assign w_global_clear  = w_stop[0] & bus.writedata[0];
    // Section 0 gates every section's counting, including on its own go cycle.
    assign w_global_enable = w_run[0] | w_go[0];
    assign w_unused        = &{1'b0, bus.writedata[31:3]};

    generate
        for (genvar k = 0; k < NUM_SECTIONS; k++) begin : g_sec
            logic                   w_hit;
            logic                   w_clrov;
            logic                   w_snap_load;
            logic                   w_tinc;
            logic                   w_einc;
            logic [31:0]            w_rd_word;
            logic                   r_run;
            logic                   r_tovf;
            logic                   r_eovf;
            logic [TIME_WIDTH-1:0]  r_time;
            logic [EVENT_WIDTH-1:0] r_event;
            logic [SNAP_W-1:0]      r_snap;

            assign w_hit       = (w_sec_idx == 32'(k));
            assign w_stop[k]   = w_wr_strobe & w_hit & (w_off == 2'd0);
            assign w_go[k]     = w_wr_strobe & w_hit & (w_off == 2'd1);
            assign w_clrov     = w_wr_strobe & w_hit & (w_off == 2'd3);
            assign w_snap_load = w_rd_strobe & w_hit & (w_off == 2'd0);
            assign w_tinc      = r_run & w_global_enable;
            assign w_einc      = w_go[k] & w_global_enable;
            assign w_run[k]    = r_run;

            // Overflow sets are written after clears so a same-cycle set wins.
            always_ff @(posedge clk) begin
                if (reset || w_global_clear) begin
                    r_run   <= 1'b0;
                    r_tovf  <= 1'b0;
                    r_eovf  <= 1'b0;
                    r_time  <= '0;
                    r_event <= '0;
                    r_snap  <= '0;
                end else begin
                    if (w_stop[k]) begin
                        r_run <= 1'b0;
                    end else if (w_go[k]) begin
                        r_run <= 1'b1;
                    end
                    if (w_clrov && bus.writedata[1]) begin
                        r_tovf <= 1'b0;
                    end
                    if (w_clrov && bus.writedata[2]) begin
                        r_eovf <= 1'b0;
                    end
                    if (w_tinc) begin
                        if (&r_time) begin
                            r_tovf <= 1'b1;
                            if (SATURATE == 0) begin
                                r_time <= '0;
                            end
                        end else begin
                            r_time <= r_time + TIME_WIDTH'(1);
                        end
                    end
                    if (w_einc) begin
                        if (&r_event) begin
                            r_eovf <= 1'b1;
                            if (SATURATE == 0) begin
                                r_event <= '0;
                            end
                        end else begin
                            r_event <= r_event + EVENT_WIDTH'(1);
                        end
                    end
                    if (w_snap_load) begin
                        r_snap <= r_time[TIME_WIDTH-1:32];
                    end
                end
            end

            always_comb begin
                w_rd_word = '0;
                if (w_hit) begin
                    case (w_off)
                        2'd0:    w_rd_word = r_time[31:0];
                        2'd1:    w_rd_word = 32'(r_snap);
                        2'd2:    w_rd_word = 32'(r_event);
                        default: w_rd_word = {29'b0, r_eovf, r_tovf, r_run};
                    endcase
                end
            end

            assign w_sec_rd[k] = w_rd_word;
        end
    endgenerate

    // Unmapped sections never hit, so the OR of all sections yields 0 for them.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            w_rd_mux = w_rd_mux | w_sec_rd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
endmodule
`default_nettype wire

// File: tb/tb_coprocessor_perf_count_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_coprocessor_perf_count_multi
// Description : Self-checking bench: wrap/64-bit, wrap/33-bit and saturating DUTs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coprocessor_perf_count_multi;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  addr;
    logic        bt;
    logic        wr;
    logic        rd;
    logic [31:0] wd;
    int          sel;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    coprocessor_perf_count_multi_if #(.AW(3)) bus_a ();
    coprocessor_perf_count_multi_if #(.AW(3)) bus_b ();
    coprocessor_perf_count_multi_if #(.AW(3)) bus_c ();

    assign bus_a.address = addr;  assign bus_b.address = addr;  assign bus_c.address = addr;
    assign bus_a.write   = wr;    assign bus_b.write   = wr;    assign bus_c.write   = wr;
    assign bus_a.read    = rd;    assign bus_b.read    = rd;    assign bus_c.read    = rd;
    assign bus_a.writedata = wd;  assign bus_b.writedata = wd;  assign bus_c.writedata = wd;
    assign bus_a.begintransfer = bt & (sel == 0);
    assign bus_b.begintransfer = bt & (sel == 1);
    assign bus_c.begintransfer = bt & (sel == 2);

    coprocessor_perf_count_multi #(.NUM_SECTIONS(2), .TIME_WIDTH(64), .EVENT_WIDTH(32), .SATURATE(0))
        u_a (.clk(clk), .reset(reset), .bus(bus_a));
    coprocessor_perf_count_multi #(.NUM_SECTIONS(2), .TIME_WIDTH(33), .EVENT_WIDTH(32), .SATURATE(0))
        u_b (.clk(clk), .reset(reset), .bus(bus_b));
    coprocessor_perf_count_multi #(.NUM_SECTIONS(2), .TIME_WIDTH(64), .EVENT_WIDTH(2), .SATURATE(1))
        u_c (.clk(clk), .reset(reset), .bus(bus_c));

    always_comb begin
        case (sel)
            0:       rdata = bus_a.readdata;
            1:       rdata = bus_b.readdata;
            default: rdata = bus_c.readdata;
        endcase
    end

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic        w;
        logic        r;
        logic [2:0]  a;
        logic [31:0] d;
        int          idle;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle; a read's expectation is queued now and checked after the edge.
    task automatic tick(input logic w, input logic r, input logic [2:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string name);
        sb_t e;
        bt = w | r; wr = w; rd = r; addr = a; wd = d;
        if (r) sb_q.push_back('{exp, name});
        @(posedge clk); #1;
        bt = 1'b0; wr = 1'b0; rd = 1'b0;
        if (r) begin
            if (sb_q.size() == 0) begin
                check({name, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check(e.name, rdata, e.exp);
            end
        end
    endtask

    task automatic wr_op(input logic [2:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, a, d, 32'd0, "");
    endtask

    task automatic rd_op(input logic [2:0] a, input logic [31:0] exp, input string name);
        tick(1'b0, 1'b1, a, 32'd0, exp, name);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, "");
    endtask

    task automatic add(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d,
                       input int n, input logic [31:0] exp, input string name);
        vt.push_back('{w, r, a, d, n, exp, name});
    endtask

    initial begin
        reset = 1'b1; bt = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wd = '0; sel = 0;

        add(1, 0, 3'd1, 32'd0, 9, 32'd0,  "");
        add(1, 0, 3'd0, 32'd0, 0, 32'd0,  "");
        add(0, 1, 3'd0, 32'd0, 0, 32'd10, "time0_after_10");
        add(0, 1, 3'd1, 32'd0, 0, 32'd0,  "snap0_zero");
        add(0, 1, 3'd2, 32'd0, 0, 32'd1,  "event0_one_go");
        add(0, 1, 3'd3, 32'd0, 0, 32'd0,  "status0_stopped");
        add(1, 0, 3'd2, 32'hFFFF_FFFF, 0, 32'd0, "");
        add(0, 1, 3'd2, 32'd0, 0, 32'd1,  "event0_wr_addr2_no_effect");
        add(0, 1, 3'd4, 32'd0, 0, 32'd0,  "time1_idle");
        add(0, 1, 3'd7, 32'd0, 0, 32'd0,  "status1_idle");

        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata_a", bus_a.readdata, 32'd0);
        check("reset_readdata_b", bus_b.readdata, 32'd0);
        check("reset_readdata_c", bus_c.readdata, 32'd0);
        reset = 1'b0;

        // Basic section-0 timing on the 64-bit wrap DUT.
        sel = 0;
        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].exp, vt[i].name);
            idle(vt[i].idle);
        end

        // Section 1 gated by section 0's run state.
        wr_op(3'd5, 32'd0);
        idle(3);
        rd_op(3'd4, 32'd0, "time1_gated_by_sec0");
        rd_op(3'd6, 32'd0, "event1_no_global_enable");
        rd_op(3'd7, 32'd1, "status1_running");
        wr_op(3'd1, 32'd0);
        idle(3);
        wr_op(3'd0, 32'd0);
        idle(2);
        rd_op(3'd4, 32'd5,  "time1_advanced_5");
        rd_op(3'd7, 32'd1,  "run1_retained_after_stop0");
        rd_op(3'd0, 32'd14, "time0_after_rerun");
        rd_op(3'd2, 32'd2,  "event0_second_go");

        // Same-cycle read returns the pre-increment value.
        wr_op(3'd1, 32'd0);
        rd_op(3'd0, 32'd14, "read_pre_increment");
        rd_op(3'd0, 32'd15, "time0_counting");
        wr_op(3'd5, 32'd0);
        rd_op(3'd6, 32'd1,  "event1_with_global_enable");

        // Snapshot holds the high word captured by the low-word read.
        force u_a.g_sec[0].r_time = 64'h0000_0001_FFFF_FFFF;
        #1;
        release u_a.g_sec[0].r_time;
        rd_op(3'd0, 32'hFFFF_FFFF, "time0_lo_at_boundary");
        idle(2);
        rd_op(3'd1, 32'd1, "snap_not_live");
        rd_op(3'd0, 32'd3, "time0_lo_after_carry");
        rd_op(3'd1, 32'd2, "snap_updated");

        // Global clear while running.
        wr_op(3'd0, 32'd1);
        for (int i = 0; i < 8; i++) rd_op(3'(i), 32'd0, $sformatf("global_clear_addr%0d", i));

        // Reset mid-count with a go strobe on the same edge.
        wr_op(3'd1, 32'd0);
        wr_op(3'd5, 32'd0);
        idle(3);
        reset = 1'b1;
        wr_op(3'd1, 32'd0);
        reset = 1'b0;
        check("readdata_after_midcount_reset", rdata, 32'd0);
        for (int i = 0; i < 8; i++) rd_op(3'(i), 32'd0, $sformatf("reset_addr%0d", i));

        // 33-bit wrap and overflow flag handling.
        sel = 1;
        wr_op(3'd1, 32'd0);
        force u_b.g_sec[0].r_time = 33'h1_FFFF_FFFE;
        #1;
        release u_b.g_sec[0].r_time;
        rd_op(3'd0, 32'hFFFF_FFFE, "b_time_lo_pre_wrap");
        rd_op(3'd1, 32'd1, "b_snap_hi_bit");
        rd_op(3'd0, 32'd0, "b_time_wrapped_zero");
        rd_op(3'd3, 32'd3, "b_status_tovf_run");
        wr_op(3'd3, 32'd4);
        rd_op(3'd3, 32'd3, "b_clr_eovf_keeps_tovf");
        wr_op(3'd3, 32'd2);
        rd_op(3'd3, 32'd1, "b_clrov_tovf");
        force u_b.g_sec[0].r_time = 33'h1_FFFF_FFFF;
        #1;
        release u_b.g_sec[0].r_time;
        wr_op(3'd3, 32'd2);
        rd_op(3'd3, 32'd3, "b_ovf_set_beats_clear");
        rd_op(3'd0, 32'd1, "b_time_after_second_wrap");

        // Saturating counters.
        sel = 2;
        repeat (5) wr_op(3'd1, 32'd0);
        rd_op(3'd2, 32'd3, "c_event_saturated");
        rd_op(3'd3, 32'd5, "c_status_eovf_run");
        force u_c.g_sec[0].r_time = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release u_c.g_sec[0].r_time;
        idle(1);
        rd_op(3'd0, 32'hFFFF_FFFF, "c_time_saturated");
        rd_op(3'd1, 32'hFFFF_FFFF, "c_snap_saturated");
        rd_op(3'd3, 32'd7, "c_status_both_ovf");
        wr_op(3'd3, 32'd6);
        rd_op(3'd3, 32'd3, "c_tovf_rearmed_eovf_cleared");

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
